// File: rtl/ctrl_mc.sv
// Multi-cycle RV32I control unit: BOOT/FETCH/EXEC/MEM sequencer over a shared req/rdy memory port,
// with illegal-instruction and memory-timeout traps and a retired-instruction counter.
module ctrl_mc #(
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int          MEM_TIMEOUT = 16,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             mem_req,
    output logic             mem_we,
    output logic [2:0]       mem_mode,
    output logic             mem_addr_sel,
    input  logic             mem_rdy,
    input  logic [31:0]      mem_rdata,
    output logic [31:0]      pc,
    output logic [31:0]      ir,
    output logic [4:0]       regA_sel,
    output logic [4:0]       regB_sel,
    output logic [4:0]       regW_sel,
    output logic             reg_wen,
    output logic [1:0]       wb_sel,
    output logic [3:0]       alu_ctrl,
    output logic             alu_a_sel,
    output logic             alu_b_sel,
    output logic [31:0]      imm,
    input  logic             alu_zero,
    input  logic [31:0]      alu_result,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic [1:0]       trap_cause
);

    typedef enum logic [2:0] {
        S_BOOT, S_FETCH, S_EXEC, S_MEM, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;

    localparam logic [1:0] CAUSE_ILL  = 2'd1;
    localparam logic [1:0] CAUSE_FTMO = 2'd2;
    localparam logic [1:0] CAUSE_DTMO = 2'd3;

    // Wait counter only needs to reach MEM_TIMEOUT-1: the next waiting cycle is the trap cycle.
    localparam int            WW   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WW-1:0] WLIM = WW'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

    state_t        state, state_nx;
    logic [31:0]   pc_nx;
    logic [1:0]    cause_nx;
    logic [WW-1:0] wcnt;
    logic          wen_raw;
    logic          tmo;
    logic          br_taken;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_itype, is_rtype;
    logic illegal;

    assign opcode   = ir[6:0];
    assign f3       = ir[14:12];
    assign regA_sel = ir[19:15];
    assign regB_sel = ir[24:20];
    assign regW_sel = ir[11:7];

    assign is_lui    = (opcode == OP_LUI);
    assign is_auipc  = (opcode == OP_AUIPC);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_itype  = (opcode == OP_ITYPE);
    assign is_rtype  = (opcode == OP_RTYPE);

    assign illegal = !(is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load
                     | is_store | is_itype | is_rtype)
                   | (is_branch & (f3[2:1] == 2'b01));

    always_comb begin
        imm = {{20{ir[31]}}, ir[31:20]};
        if (is_store)
            imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
        else if (is_branch)
            imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        else if (is_lui | is_auipc)
            imm = {ir[31:12], 12'b0};
        else if (is_jal)
            imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    end

    // Branches compare via sub (eq/ne), slt (lt/ge) or sltu (ltu/geu); zero then encodes the outcome.
    always_comb begin
        alu_ctrl = 4'b0000;
        if (is_rtype)
            alu_ctrl = {ir[30], f3};
        else if (is_itype)
            alu_ctrl = {(f3 == 3'b101) & ir[30], f3};
        else if (is_lui)
            alu_ctrl = 4'b1111;
        else if (is_branch) begin
            case (f3[2:1])
                2'b10:   alu_ctrl = 4'b0010;
                2'b11:   alu_ctrl = 4'b0011;
                default: alu_ctrl = 4'b1000;
            endcase
        end
    end

    always_comb begin
        case (f3)
            3'b000, 3'b101, 3'b111: br_taken = alu_zero;
            default:                br_taken = !alu_zero;
        endcase
    end

    assign alu_a_sel = is_auipc;
    assign alu_b_sel = !(is_rtype | is_branch);
    assign wb_sel    = (state == S_MEM) ? 2'd1 : ((is_jal | is_jalr) ? 2'd2 : 2'd0);
    assign trap      = (state == S_TRAP);
    assign reg_wen   = wen_raw && (regW_sel != 5'd0);
    assign tmo       = (MEM_TIMEOUT != 0) && !mem_rdy && (wcnt == WLIM);

    always_comb begin
        state_nx     = state;
        pc_nx        = pc;
        cause_nx     = trap_cause;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_mode     = 3'b010;
        mem_addr_sel = 1'b0;
        wen_raw      = 1'b0;
        retire       = 1'b0;
        case (state)
            S_BOOT: state_nx = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_rdy) begin
                    state_nx = S_EXEC;
                end else if (tmo) begin
                    state_nx = S_TRAP;
                    cause_nx = CAUSE_FTMO;
                end
            end
            S_EXEC: begin
                if (illegal) begin
                    state_nx = S_TRAP;
                    cause_nx = CAUSE_ILL;
                end else if (is_load | is_store) begin
                    state_nx = S_MEM;
                end else begin
                    state_nx = S_FETCH;
                    retire   = 1'b1;
                    wen_raw  = !is_branch;
                    if (is_jal | (is_branch & br_taken))
                        pc_nx = pc + imm;
                    else if (is_jalr)
                        pc_nx = alu_result & ~32'h1;
                    else
                        pc_nx = pc + 32'd4;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = is_store;
                mem_mode     = f3;
                if (mem_rdy) begin
                    state_nx = S_FETCH;
                    wen_raw  = is_load;
                    retire   = 1'b1;
                    pc_nx    = pc + 32'd4;
                end else if (tmo) begin
                    state_nx = S_TRAP;
                    cause_nx = CAUSE_DTMO;
                end
            end
            default: state_nx = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_BOOT;
            pc         <= RESET_PC;
            ir         <= 32'h0;
            instret    <= '0;
            trap_cause <= 2'd0;
            wcnt       <= '0;
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            trap_cause <= cause_nx;
            if (state == S_FETCH && mem_rdy)
                ir <= mem_rdata;
            if (retire)
                instret <= instret + 1'b1;
            // Completion or an idle port clears the count, so each transaction starts from zero.
            if (!mem_req || mem_rdy)
                wcnt <= '0;
            else if (wcnt != WLIM)
                wcnt <= wcnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ctrl_mc.sv
// Directed bench for ctrl_mc: the bench plays memory and ALU cycle by cycle and checks
// sequencing, decode, traps, timeouts and the instret counter against hand-computed values.
module tb_ctrl_mc;

    localparam int CNT_W = 2;

    localparam logic [31:0] I_ADDI = 32'h00500093; // addi x1,x0,5
    localparam logic [31:0] I_LW   = 32'h0000A103; // lw   x2,0(x1)
    localparam logic [31:0] I_NOP  = 32'h00000013; // addi x0,x0,0
    localparam logic [31:0] I_BEQ  = 32'hFE000CE3; // beq  x0,x0,-8
    localparam logic [31:0] I_JALR = 32'h003180E7; // jalr x1,3(x3)
    localparam logic [31:0] I_JAL  = 32'h0080006F; // jal  x0,+8
    localparam logic [31:0] I_SW   = 32'h0020A223; // sw   x2,4(x1)
    localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             mem_req, mem_we, mem_addr_sel;
    logic [2:0]       mem_mode;
    logic             mem_rdy = 1'b0;
    logic [31:0]      mem_rdata = 32'h0;
    logic [31:0]      pc, ir, imm;
    logic [4:0]       regA_sel, regB_sel, regW_sel;
    logic             reg_wen, alu_a_sel, alu_b_sel, retire, trap;
    logic [1:0]       wb_sel, trap_cause;
    logic [3:0]       alu_ctrl;
    logic             alu_zero = 1'b0;
    logic [31:0]      alu_result = 32'h0;
    logic [CNT_W-1:0] instret;

    int checks = 0;
    int errors = 0;

    ctrl_mc #(.RESET_PC(32'h0), .MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_mode(mem_mode), .mem_addr_sel(mem_addr_sel),
        .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
        .pc(pc), .ir(ir),
        .regA_sel(regA_sel), .regB_sel(regB_sel), .regW_sel(regW_sel),
        .reg_wen(reg_wen), .wb_sel(wb_sel), .alu_ctrl(alu_ctrl),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .imm(imm),
        .alu_zero(alu_zero), .alu_result(alu_result),
        .retire(retire), .instret(instret), .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serve one zero-wait fetch; leaves the DUT in EXEC.
    task automatic fetch(input logic [31:0] inst);
        mem_rdy   = 1'b1;
        mem_rdata = inst;
        tick();
        mem_rdy   = 1'b0;
        mem_rdata = 32'h0;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_rdy = 1'b0;
        alu_zero = 1'b0;
        alu_result = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", mem_req); end
        checks++; if ({mem_we, reg_wen, retire, trap} !== 4'b0) begin errors++; $display("FAIL rst_strobes: got %b exp 0000", {mem_we, reg_wen, retire, trap}); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h exp 0", pc); end
        checks++; if (ir !== 32'h0) begin errors++; $display("FAIL rst_ir: got %h exp 0", ir); end
        checks++; if (instret !== 2'd0) begin errors++; $display("FAIL rst_instret: got %0d exp 0", instret); end
        checks++; if (trap_cause !== 2'd0) begin errors++; $display("FAIL rst_cause: got %0d exp 0", trap_cause); end
        tick();
        checks++; if ({mem_req, mem_we, mem_addr_sel, mem_mode} !== 6'b100010) begin errors++; $display("FAIL fetch_port: got %b exp 100010", {mem_req, mem_we, mem_addr_sel, mem_mode}); end
    endtask

    task automatic test_alu();
        fetch(I_ADDI);
        checks++; if (ir !== I_ADDI) begin errors++; $display("FAIL addi_ir: got %h exp %h", ir, I_ADDI); end
        checks++; if ({reg_wen, retire, wb_sel} !== 4'b1100) begin errors++; $display("FAIL addi_wen: got %b exp 1100", {reg_wen, retire, wb_sel}); end
        checks++; if ({regW_sel, imm} !== {5'd1, 32'd5}) begin errors++; $display("FAIL addi_dec: got %0d/%h exp 1/5", regW_sel, imm); end
        checks++; if ({alu_b_sel, alu_a_sel, alu_ctrl, mem_req} !== 7'b1000000) begin errors++; $display("FAIL addi_alu: got %b exp 1000000", {alu_b_sel, alu_a_sel, alu_ctrl, mem_req}); end
        tick();
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL addi_pc: got %h exp 4", pc); end
        checks++; if (instret !== 2'd1) begin errors++; $display("FAIL addi_instret: got %0d exp 1", instret); end
    endtask

    task automatic test_load_wait();
        fetch(I_LW);
        checks++; if ({reg_wen, retire, mem_req} !== 3'b000) begin errors++; $display("FAIL lw_exec: got %b exp 000", {reg_wen, retire, mem_req}); end
        checks++; if ({regA_sel, imm} !== {5'd1, 32'd0}) begin errors++; $display("FAIL lw_dec: got %0d/%h exp 1/0", regA_sel, imm); end
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_rdy   = (i == 3);
            mem_rdata = 32'h1234;
            #1;
            checks++; if ({mem_req, mem_addr_sel, mem_we, mem_mode} !== 6'b110010) begin errors++; $display("FAIL lw_port%0d: got %b exp 110010", i, {mem_req, mem_addr_sel, mem_we, mem_mode}); end
            checks++; if ({reg_wen, retire} !== {2{i == 3}}) begin errors++; $display("FAIL lw_wen%0d: got %b exp %b", i, {reg_wen, retire}, {2{i == 3}}); end
            if (i == 3) begin
                checks++; if (wb_sel !== 2'd1) begin errors++; $display("FAIL lw_wbsel: got %0d exp 1", wb_sel); end
            end
            tick();
        end
        mem_rdy = 1'b0;
        checks++; if (pc !== 32'h8) begin errors++; $display("FAIL lw_pc: got %h exp 8", pc); end
        checks++; if (instret !== 2'd2) begin errors++; $display("FAIL lw_instret: got %0d exp 2", instret); end
    endtask

    task automatic test_x0_wrap();
        fetch(I_NOP);
        checks++; if ({reg_wen, retire} !== 2'b01) begin errors++; $display("FAIL x0_wen: got %b exp 01", {reg_wen, retire}); end
        tick();
        checks++; if (instret !== 2'd3) begin errors++; $display("FAIL nop_instret: got %0d exp 3", instret); end
        fetch(I_NOP);
        tick();
        checks++; if (instret !== 2'd0) begin errors++; $display("FAIL wrap_instret: got %0d exp 0", instret); end
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL nop_pc: got %h exp 10", pc); end
    endtask

    task automatic test_branch();
        fetch(I_BEQ);
        alu_zero = 1'b1;
        #1;
        checks++; if (imm !== 32'hFFFFFFF8) begin errors++; $display("FAIL beq_imm: got %h exp fffffff8", imm); end
        checks++; if ({alu_ctrl, alu_b_sel} !== 5'b10000) begin errors++; $display("FAIL beq_alu: got %b exp 10000", {alu_ctrl, alu_b_sel}); end
        checks++; if ({reg_wen, retire} !== 2'b01) begin errors++; $display("FAIL beq_wen: got %b exp 01", {reg_wen, retire}); end
        tick();
        alu_zero = 1'b0;
        checks++; if (pc !== 32'h8) begin errors++; $display("FAIL beq_taken_pc: got %h exp 8", pc); end
        fetch(I_NOP); tick();
        fetch(I_NOP); tick();
        fetch(I_BEQ);
        tick();
        checks++; if (pc !== 32'h14) begin errors++; $display("FAIL beq_nt_pc: got %h exp 14", pc); end
        checks++; if (instret !== 2'd0) begin errors++; $display("FAIL beq_instret: got %0d exp 0", instret); end
    endtask

    task automatic test_jump();
        fetch(I_JALR);
        alu_result = 32'h103;
        #1;
        checks++; if ({reg_wen, wb_sel, alu_b_sel} !== 4'b1101) begin errors++; $display("FAIL jalr_ctl: got %b exp 1101", {reg_wen, wb_sel, alu_b_sel}); end
        checks++; if ({regA_sel, imm} !== {5'd3, 32'd3}) begin errors++; $display("FAIL jalr_dec: got %0d/%h exp 3/3", regA_sel, imm); end
        tick();
        alu_result = 32'h0;
        checks++; if (pc !== 32'h102) begin errors++; $display("FAIL jalr_pc: got %h exp 102", pc); end
        fetch(I_JAL);
        checks++; if ({reg_wen, retire, wb_sel} !== 4'b0110) begin errors++; $display("FAIL jal_ctl: got %b exp 0110", {reg_wen, retire, wb_sel}); end
        checks++; if (imm !== 32'h8) begin errors++; $display("FAIL jal_imm: got %h exp 8", imm); end
        tick();
        checks++; if (pc !== 32'h10A) begin errors++; $display("FAIL jal_pc: got %h exp 10a", pc); end
    endtask

    task automatic test_store();
        fetch(I_SW);
        checks++; if ({regB_sel, imm} !== {5'd2, 32'd4}) begin errors++; $display("FAIL sw_dec: got %0d/%h exp 2/4", regB_sel, imm); end
        tick();
        mem_rdy = 1'b1;
        #1;
        checks++; if ({mem_req, mem_addr_sel, mem_we, mem_mode} !== 6'b111010) begin errors++; $display("FAIL sw_port: got %b exp 111010", {mem_req, mem_addr_sel, mem_we, mem_mode}); end
        checks++; if ({reg_wen, retire} !== 2'b01) begin errors++; $display("FAIL sw_wen: got %b exp 01", {reg_wen, retire}); end
        tick();
        mem_rdy = 1'b0;
        checks++; if (pc !== 32'h10E) begin errors++; $display("FAIL sw_pc: got %h exp 10e", pc); end
        checks++; if (instret !== 2'd3) begin errors++; $display("FAIL sw_instret: got %0d exp 3", instret); end
    endtask

    task automatic test_illegal();
        fetch(I_BAD);
        checks++; if ({reg_wen, retire, trap} !== 3'b000) begin errors++; $display("FAIL ill_exec: got %b exp 000", {reg_wen, retire, trap}); end
        tick();
        checks++; if ({trap, trap_cause, mem_req} !== 4'b1010) begin errors++; $display("FAIL ill_trap: got %b exp 1010", {trap, trap_cause, mem_req}); end
        checks++; if (pc !== 32'h10E) begin errors++; $display("FAIL ill_pc: got %h exp 10e", pc); end
        mem_rdy = 1'b1;
        mem_rdata = I_NOP;
        tick(); tick();
        mem_rdy = 1'b0;
        checks++; if ({trap, mem_req, pc, ir} !== {2'b10, 32'h10E, I_BAD}) begin errors++; $display("FAIL trap_frozen: got %b %b %h %h", trap, mem_req, pc, ir); end
        checks++; if (instret !== 2'd3) begin errors++; $display("FAIL trap_instret: got %0d exp 3", instret); end
    endtask

    task automatic test_timeout();
        do_reset();
        tick();
        for (int i = 0; i < 3; i++) tick();
        checks++; if ({trap, mem_req} !== 2'b01) begin errors++; $display("FAIL ftmo_early: got %b exp 01", {trap, mem_req}); end
        tick();
        checks++; if ({trap, trap_cause, mem_req} !== 4'b1100) begin errors++; $display("FAIL ftmo_trap: got %b exp 1100", {trap, trap_cause, mem_req}); end
        do_reset();
        tick();
        fetch(I_LW);
        tick();
        for (int i = 0; i < 3; i++) tick();
        checks++; if ({trap, mem_req, mem_addr_sel} !== 3'b011) begin errors++; $display("FAIL dtmo_early: got %b exp 011", {trap, mem_req, mem_addr_sel}); end
        tick();
        checks++; if ({trap, trap_cause, pc} !== {1'b1, 2'd3, 32'h0}) begin errors++; $display("FAIL dtmo_trap: got %b %0d %h exp 1 3 0", trap, trap_cause, pc); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick();
        fetch(I_ADDI);
        tick();
        fetch(I_LW);
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL async_req: got %b exp 0", mem_req); end
        checks++; if ({pc, ir, instret} !== {32'h0, 32'h0, 2'd0}) begin errors++; $display("FAIL async_regs: got %h %h %0d exp 0 0 0", pc, ir, instret); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL boot_req: got %b exp 0", mem_req); end
        tick();
        checks++; if ({mem_req, mem_addr_sel, pc} !== {2'b10, 32'h0}) begin errors++; $display("FAIL refetch: got %b %b %h exp 1 0 0", mem_req, mem_addr_sel, pc); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_wait();
        test_x0_wrap();
        test_branch();
        test_jump();
        test_store();
        test_illegal();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
